// File: rtl/traffic_pkg.sv
// Shared grant identifiers, arbiter state encoding and the winner-selection rule
// used by the phase-request arbiter.
package traffic_pkg;

  localparam logic [1:0] GRANT_NONE    = 2'd0;
  localparam logic [1:0] GRANT_WALK    = 2'd1;
  localparam logic [1:0] GRANT_SENSOR  = 2'd2;
  localparam logic [1:0] GRANT_PREEMPT = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    SERVE = 2'd2
  } arb_state_e;

  // aged[0]/aged[1] flag walk/sensor requests that have waited too long;
  // last_served is the walk/sensor id that most recently completed.
  function automatic logic [1:0] select_winner(input logic [2:0] pend,
                                               input logic [1:0] aged,
                                               input logic [1:0] last_served);
    logic [1:0] rr_pick;
    rr_pick = (last_served == GRANT_WALK) ? GRANT_SENSOR : GRANT_WALK;
    if (pend[2])           return GRANT_PREEMPT;
    else if (&aged)        return rr_pick;
    else if (aged[0])      return GRANT_WALK;
    else if (aged[1])      return GRANT_SENSOR;
    else if (&pend[1:0])   return rr_pick;
    else if (pend[0])      return GRANT_WALK;
    else if (pend[1])      return GRANT_SENSOR;
    else                   return GRANT_NONE;
  endfunction

endpackage

// File: rtl/req_age_counter.sv
// 4-bit saturating age counter for one latched request; clear has priority
// over increment so a serviced request always restarts from zero.
module req_age_counter (
  input  logic       clk,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       inc_i,
  output logic [3:0] age_o
);

  logic [3:0] age_q;

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      age_q <= '0;
    end else if (clr_i) begin
      age_q <= '0;
    end else if (inc_i && (age_q != 4'hF)) begin
      age_q <= age_q + 4'd1;
    end
  end

  assign age_o = age_q;

endmodule

// File: rtl/phase_request_arbiter.sv
// Latches walk/sensor/preempt requests and offers one grant at a time to the
// traffic FSM over a valid/ack handshake, with aging and a service timeout.
module phase_request_arbiter
  import traffic_pkg::*;
#(
  parameter logic [3:0] MAX_WAIT      = 4'd12,
  parameter logic [3:0] GRANT_TIMEOUT = 4'd15
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       oneHz_enable,
  input  logic       WR_Sync,
  input  logic       Sensor_Sync,
  input  logic       Preempt_Sync,
  input  logic       phase_busy,
  input  logic       grant_ack,
  input  logic       phase_done,
  output logic       grant_valid,
  output logic [1:0] grant_id,
  output logic [2:0] pending,
  output logic       timeout_err
);

  arb_state_e state_q, state_d;
  logic [2:0] pending_q, pending_d;
  logic [2:0] clear_vec;
  logic       grant_valid_q, grant_valid_d;
  logic [1:0] grant_id_q, grant_id_d;
  logic [1:0] rr_q, rr_d;
  logic [3:0] timer_q, timer_d;
  logic       timeout_err_q, timeout_err_d;
  logic [3:0] age_w [2];
  logic [1:0] aged;
  logic [1:0] winner;
  logic       offer_start;
  logic       serve_done;
  logic       serve_timeout;

  assign offer_start   = (state_q == IDLE) && (|pending_q) && !phase_busy;
  assign serve_done    = (state_q == SERVE) && phase_done;
  // A done pulse in the same cycle as the final tick counts as a normal completion.
  assign serve_timeout = (state_q == SERVE) && !phase_done && oneHz_enable &&
                         (timer_q == (GRANT_TIMEOUT - 4'd1));

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_clear
      assign clear_vec[gi] = (serve_done || serve_timeout) && (grant_id_q == 2'(gi + 1));
    end
    for (gi = 0; gi < 2; gi++) begin : g_age
      req_age_counter u_age (
        .clk   (clk),
        .rst_i (Reset),
        .clr_i (clear_vec[gi]),
        .inc_i (oneHz_enable && pending_q[gi]),
        .age_o (age_w[gi])
      );
      assign aged[gi] = pending_q[gi] && (age_w[gi] >= MAX_WAIT);
    end
  endgenerate

  // New requests take precedence over a same-cycle clear.
  assign pending_d = (pending_q & ~clear_vec) | {Preempt_Sync, Sensor_Sync, WR_Sync};
  assign winner    = select_winner(pending_q, aged, rr_q);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q       <= IDLE;
      pending_q     <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= GRANT_NONE;
      rr_q          <= GRANT_WALK;
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      grant_valid_q <= grant_valid_d;
      grant_id_q    <= grant_id_d;
      rr_q          <= rr_d;
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (offer_start) state_d = OFFER;
      OFFER:   if (grant_ack) state_d = SERVE;
      SERVE:   if (serve_done || serve_timeout) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_valid_d = grant_valid_q;
    grant_id_d    = grant_id_q;
    rr_d          = rr_q;
    timer_d       = timer_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE: begin
        grant_valid_d = 1'b0;
        grant_id_d    = GRANT_NONE;
        timer_d       = '0;
        if (offer_start) begin
          grant_valid_d = 1'b1;
          grant_id_d    = winner;
        end
      end
      OFFER: begin
        timer_d = '0;
        // An unacknowledged offer yields to a freshly latched preempt.
        if (!grant_ack && pending_q[2] && (grant_id_q != GRANT_PREEMPT)) begin
          grant_id_d = GRANT_PREEMPT;
        end
      end
      SERVE: begin
        if (serve_done) begin
          grant_valid_d = 1'b0;
          grant_id_d    = GRANT_NONE;
          if (grant_id_q != GRANT_PREEMPT) rr_d = grant_id_q;
        end else if (serve_timeout) begin
          grant_valid_d = 1'b0;
          grant_id_d    = GRANT_NONE;
          timeout_err_d = 1'b1;
        end else if (oneHz_enable) begin
          timer_d = timer_q + 4'd1;
        end
      end
      default: begin
        grant_valid_d = 1'b0;
        grant_id_d    = GRANT_NONE;
      end
    endcase
  end

  assign grant_valid = grant_valid_q;
  assign grant_id    = grant_id_q;
  assign pending     = pending_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_phase_request_arbiter.sv
// Scoreboard bench: stimulus pushes expected offers/releases computed by a
// request-level model; a negedge monitor pops and compares on each DUT event.
module tb_phase_request_arbiter;

  logic       clk;
  logic       Reset;
  logic       oneHz_enable;
  logic       WR_Sync;
  logic       Sensor_Sync;
  logic       Preempt_Sync;
  logic       phase_busy;
  logic       grant_ack;
  logic       phase_done;
  logic       grant_valid;
  logic [1:0] grant_id;
  logic [2:0] pending;
  logic       timeout_err;

  phase_request_arbiter dut (
    .clk          (clk),
    .Reset        (Reset),
    .oneHz_enable (oneHz_enable),
    .WR_Sync      (WR_Sync),
    .Sensor_Sync  (Sensor_Sync),
    .Preempt_Sync (Preempt_Sync),
    .phase_busy   (phase_busy),
    .grant_ack    (grant_ack),
    .phase_done   (phase_done),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .pending      (pending),
    .timeout_err  (timeout_err)
  );

  typedef struct {
    logic       rel;
    logic       err;
    logic [1:0] id;
    logic [2:0] pend;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 0;

  // Request-level reference state: pending set, ages in seconds, last served, error flag.
  logic [2:0] m_pend;
  int         m_age [1:2];
  int         m_last;
  logic       m_err;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int choose();
    int aged[$];
    int cand[$];
    if (m_pend[2]) return 3;
    for (int i = 1; i <= 2; i++) begin
      if (m_pend[i-1]) begin
        cand.push_back(i);
        if (m_age[i] >= 12) aged.push_back(i);
      end
    end
    if (aged.size() == 1) return aged[0];
    if (aged.size() == 2 || cand.size() == 2) return (m_last == 1) ? 2 : 1;
    if (cand.size() == 1) return cand[0];
    return 0;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_age[1] = 0;
    m_age[2] = 0;
    m_last = 1;
    m_err = 1'b0;
  endtask

  task automatic model_tick();
    for (int i = 1; i <= 2; i++)
      if (m_pend[i-1] && m_age[i] < 15) m_age[i]++;
  endtask

  task automatic model_clear(input int w);
    m_pend[w-1] = 1'b0;
    if (w < 3) m_age[w] = 0;
  endtask

  task automatic push_offer(input int w);
    exp_t e;
    e.rel = 1'b0; e.err = m_err; e.id = 2'(w); e.pend = m_pend;
    exp_q.push_back(e);
  endtask

  task automatic push_release();
    exp_t e;
    e.rel = 1'b1; e.err = m_err; e.id = 2'd0; e.pend = m_pend;
    exp_q.push_back(e);
  endtask

  task automatic tick();
    oneHz_enable = 1'b1;
    model_tick();
    step();
    oneHz_enable = 1'b0;
    step();
  endtask

  task automatic pulse(input logic wr, input logic sn, input logic pe);
    WR_Sync = wr; Sensor_Sync = sn; Preempt_Sync = pe;
    m_pend = m_pend | {pe, sn, wr};
    step();
    WR_Sync = 1'b0; Sensor_Sync = 1'b0; Preempt_Sync = 1'b0;
  endtask

  // mode: 0 done after nticks, 1 timeout, 2 done on the final tick, 3 reset mid-serve
  task automatic ack_and_serve(input int w, input int mode, input int nticks);
    grant_ack = 1'b1;
    step();
    grant_ack = 1'b0;
    step();
    case (mode)
      1: begin
        repeat (14) tick();
        model_tick();
        model_clear(w);
        m_err = 1'b1;
        push_release();
        oneHz_enable = 1'b1;
        step();
        oneHz_enable = 1'b0;
      end
      2: begin
        repeat (14) tick();
        model_tick();
        model_clear(w);
        if (w < 3) m_last = w;
        push_release();
        oneHz_enable = 1'b1; phase_done = 1'b1;
        step();
        oneHz_enable = 1'b0; phase_done = 1'b0;
      end
      3: begin
        repeat (nticks) tick();
        model_reset();
        push_release();
        #1 Reset = 1'b1;
        #1 check("reset_drop", {4'd0, grant_valid, pending}, 8'd0);
        step();
        Reset = 1'b0;
      end
      default: begin
        repeat (nticks) tick();
        model_clear(w);
        if (w < 3) m_last = w;
        push_release();
        phase_done = 1'b1;
        step();
        phase_done = 1'b0;
      end
    endcase
    step();
    step();
  endtask

  task automatic run_round(input bit reoffer, input int mode, input int nticks);
    int w;
    int waitc;
    w = choose();
    push_offer(w);
    phase_busy = 1'b0;
    waitc = 0;
    step();
    while (!grant_valid && waitc < 10) begin
      step();
      waitc++;
    end
    phase_busy = 1'b1;
    if (!grant_valid) begin
      checks++;
      errors++;
      $display("FAIL offer_wait actual=no_grant required=grant_id_%0d", w);
      void'(exp_q.pop_back());
      return;
    end
    step();
    if (reoffer && w != 3) begin
      pulse(1'b0, 1'b0, 1'b1);
      push_offer(3);
      w = 3;
      step();
      step();
    end
    ack_and_serve(w, mode, nticks);
  endtask

  task automatic rand_setup();
    int n;
    n = $urandom_range(1, 12);
    for (int k = 0; k < n; k++) begin
      case ($urandom_range(0, 3))
        0: pulse(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 5) == 0));
        1, 2: tick();
        default: step();
      endcase
    end
    if (m_pend == 3'b000) pulse(1'b1, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic prev_valid;
    logic [1:0] prev_id;
    if (mon_en) begin
      if ((grant_valid && (!prev_valid || grant_id != prev_id)) || (prev_valid && !grant_valid)) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event actual valid=%0b id=%0d required=no_event",
                   grant_valid, grant_id);
        end else begin
          e = exp_q.pop_front();
          check(grant_valid ? "offer" : "release",
                {1'b0, !grant_valid, timeout_err, grant_id, pending},
                {1'b0, e.rel, e.err, e.id, e.pend});
        end
      end
    end
    prev_valid = grant_valid;
    prev_id    = grant_id;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; oneHz_enable = 1'b0; WR_Sync = 1'b0; Sensor_Sync = 1'b0;
    Preempt_Sync = 1'b0; phase_busy = 1'b0; grant_ack = 1'b0; phase_done = 1'b0;
    model_reset();
    #1 Reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 Reset = 1'b0;
    check("reset_state", {3'd0, grant_valid, grant_id, pending[1:0]}, 8'd0);
    check("reset_flags", {4'd0, timeout_err, pending}, 8'd0);
    mon_en = 1'b1;
    step();

    // single walk request: offer appears exactly two cycles after the input
    WR_Sync = 1'b1;
    m_pend[0] = 1'b1;
    push_offer(choose());
    step();
    WR_Sync = 1'b0;
    check("latency_early", {7'd0, grant_valid}, 8'd0);
    step();
    check("latency_offer", {5'd0, grant_valid, grant_id}, {5'd0, 1'b1, 2'd1});
    phase_busy = 1'b1;
    step();
    ack_and_serve(1, 0, 0);
    check("walk_cleared", {5'd0, pending}, {5'd0, m_pend});

    // round-robin alternation with both requests pending
    for (int k = 0; k < 4; k++) begin
      pulse(1'b1, 1'b1, 1'b0);
      run_round(1'b0, 0, 0);
    end

    // preempt replaces an unacknowledged offer, then the other request returns
    run_round(1'b1, 0, 0);
    run_round(1'b0, 0, 2);

    // reset while serving
    pulse(1'b1, 1'b0, 1'b0);
    run_round(1'b0, 3, 3);

    // aged walk beats round-robin
    pulse(1'b1, 1'b0, 1'b0);
    repeat (12) tick();
    pulse(1'b0, 1'b1, 1'b0);
    run_round(1'b0, 0, 0);

    // service timeout, then reset clears the sticky error
    pulse(1'b0, 1'b1, 1'b0);
    run_round(1'b0, 1, 0);
    check("timeout_sticky", {4'd0, timeout_err, pending}, {4'd0, 1'b1, m_pend});
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    model_reset();
    step();
    check("timeout_cleared", {7'd0, timeout_err}, 8'd0);

    for (int r = 0; r < 60; r++) begin
      int sel;
      int mode;
      rand_setup();
      sel = $urandom_range(0, 9);
      mode = (sel == 6) ? 1 : (sel == 7) ? 2 : (sel == 8) ? 3 : 0;
      run_round(1'($urandom_range(0, 3) == 0), mode, $urandom_range(0, 14));
    end

    repeat (4) step();
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
